// File: rtl/aec_result_formatter.sv
// aec_result_formatter: buffers evaluator results in a small FIFO, converts
// each to decimal with a serial double-dabble, and streams the ASCII digits
// (leading zeros suppressed) plus a terminator over a valid/ready byte port.
module aec_result_formatter #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [7:0]  TERM_CHAR  = 8'h0A,
    parameter int          CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid,
    input  logic [6:0]    result,
    output logic [7:0]    ascii_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          overflow,
    output logic [CW-1:0] fifo_count
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        EMIT_H,
        EMIT_T,
        EMIT_U,
        EMIT_TERM
    } state_t;

    state_t          state, state_nxt;

    logic [6:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            push, pop;

    logic [6:0]      sr;
    logic [3:0]      bh, bt, bu;
    logic [2:0]      step;
    logic [3:0]      ah, at, au;
    logic [3:0]      nh, nt, nu;
    logic            hs;

    // Fullness is judged on the start-of-cycle count, so a same-cycle pop
    // never makes room for a push into a full FIFO.
    assign push = valid && (count != CW'(FIFO_DEPTH));
    assign pop  = (state == IDLE) && (count != '0);
    assign hs   = out_valid && out_ready;

    // FIFO storage; contents need no reset since pointers/count define validity
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= result;
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (valid && !push) overflow <= 1'b1;
        end
    end

    // One double-dabble step: add 3 to digits >= 5, then shift the whole
    // {H,T,U,sr} chain left by one.
    always_comb begin
        ah = (bh >= 4'd5) ? bh + 4'd3 : bh;
        at = (bt >= 4'd5) ? bt + 4'd3 : bt;
        au = (bu >= 4'd5) ? bu + 4'd3 : bu;
        nh = {ah[2:0], at[3]};
        nt = {at[2:0], au[3]};
        nu = {au[2:0], sr[6]};
    end

    // Converter registers: load on pop, step while in CONV, hold while emitting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr   <= '0;
            bh   <= '0;
            bt   <= '0;
            bu   <= '0;
            step <= '0;
        end else if (pop) begin
            sr   <= mem[rd_ptr];
            bh   <= '0;
            bt   <= '0;
            bu   <= '0;
            step <= '0;
        end else if (state == CONV) begin
            sr   <= {sr[5:0], 1'b0};
            bh   <= nh;
            bt   <= nt;
            bu   <= nu;
            step <= step + 3'd1;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; the leading-zero skip looks at the post-step digits
    // because the final step and the exit from CONV share one edge.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (count != '0) state_nxt = CONV;
            CONV: begin
                if (step == 3'd6) begin
                    if (nh != 4'd0)      state_nxt = EMIT_H;
                    else if (nt != 4'd0) state_nxt = EMIT_T;
                    else                 state_nxt = EMIT_U;
                end
            end
            EMIT_H:    if (hs) state_nxt = EMIT_T;
            EMIT_T:    if (hs) state_nxt = EMIT_U;
            EMIT_U:    if (hs) state_nxt = EMIT_TERM;
            EMIT_TERM: if (hs) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Output character decode; ascii_out is zero whenever nothing is offered
    always_comb begin
        out_valid = 1'b0;
        ascii_out = 8'h00;
        case (state)
            EMIT_H:    begin out_valid = 1'b1; ascii_out = {4'h3, bh}; end
            EMIT_T:    begin out_valid = 1'b1; ascii_out = {4'h3, bt}; end
            EMIT_U:    begin out_valid = 1'b1; ascii_out = {4'h3, bu}; end
            EMIT_TERM: begin out_valid = 1'b1; ascii_out = TERM_CHAR;  end
            default:   ;
        endcase
    end

    assign busy       = (state != IDLE) || (count != '0);
    assign fifo_count = count;

endmodule

// File: tb/tb_aec_result_formatter.sv
// Directed + random bench for aec_result_formatter.
module tb_aec_result_formatter;

    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid;
    logic [6:0]    result;
    logic [7:0]    ascii_out;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          overflow;
    logic [CW-1:0] fifo_count;

    aec_result_formatter dut (
        .clk        (clk),
        .rst        (rst),
        .valid      (valid),
        .result     (result),
        .ascii_out  (ascii_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]      val;
        int              nb;
        logic [3:0][7:0] b;
    } vec_t;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [7:0]  rx[$];
    logic [7:0]  exp_q[$];
    int          base;
    vec_t        tv[10];

    // Accepted bytes are recorded mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) rx.push_back(ascii_out);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [6:0] v, input int nb,
                                input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input logic [7:0] b3);
        vec_t t;
        t.val = v;
        t.nb  = nb;
        t.b   = {b3, b2, b1, b0};
        return t;
    endfunction

    // Reference decimal formatting
    task automatic fmt(input int v);
        if (v >= 100) exp_q.push_back(8'(8'h30 + v / 100));
        if (v >= 10)  exp_q.push_back(8'(8'h30 + (v / 10) % 10));
        exp_q.push_back(8'(8'h30 + v % 10));
        exp_q.push_back(8'h0A);
    endtask

    // Pulse valid once and measure cycles from capture edge to out_valid
    task automatic send_meas(input logic [6:0] v, output int lat);
        @(posedge clk); #1;
        valid  = 1'b1;
        result = v;
        @(posedge clk); #1;
        valid  = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic wait_bytes(input int n);
        int t = 0;
        while (rx.size() < base + n && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        if (rx.size() < base + n) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_bytes: got %0d bytes, expected %0d", rx.size() - base, n);
        end
    endtask

    task automatic cmp_exp(input string name);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < rx.size()) chk(name, rx[base + i], exp_q[i]);
            else                      chk(name, 32'hFFFF_FFFF, exp_q[i]);
        end
    endtask

    initial begin
        int lat;
        int gap;
        int sent;

        tv[0] = mk(7'd7,   2, 8'h37, 8'h0A, 8'h00, 8'h00);
        tv[1] = mk(7'd0,   2, 8'h30, 8'h0A, 8'h00, 8'h00);
        tv[2] = mk(7'd105, 4, 8'h31, 8'h30, 8'h35, 8'h0A);
        tv[3] = mk(7'd5,   2, 8'h35, 8'h0A, 8'h00, 8'h00);
        tv[4] = mk(7'd9,   2, 8'h39, 8'h0A, 8'h00, 8'h00);
        tv[5] = mk(7'd10,  3, 8'h31, 8'h30, 8'h0A, 8'h00);
        tv[6] = mk(7'd99,  3, 8'h39, 8'h39, 8'h0A, 8'h00);
        tv[7] = mk(7'd100, 4, 8'h31, 8'h30, 8'h30, 8'h0A);
        tv[8] = mk(7'd127, 4, 8'h31, 8'h32, 8'h37, 8'h0A);
        tv[9] = mk(7'd50,  3, 8'h35, 8'h30, 8'h0A, 8'h00);

        rst = 1'b1; valid = 1'b0; result = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst_ascii",    ascii_out,  8'h00);
        chk("rst_valid",    out_valid,  1'b0);
        chk("rst_busy",     busy,       1'b0);
        chk("rst_overflow", overflow,   1'b0);
        chk("rst_count",    fifo_count, 0);

        // Table: each result from an idle formatter, sink always ready
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            base = rx.size();
            send_meas(tv[i].val, lat);
            chk("latency", lat, 8);
            wait_bytes(tv[i].nb);
            for (int j = 0; j < tv[i].nb; j++) begin
                if (base + j < rx.size()) chk("tbl_byte", rx[base + j], tv[i].b[j]);
            end
            chk("idle_busy", busy, 1'b0);
        end

        // Stall: first character must hold while the sink is not ready
        out_ready = 1'b0;
        base = rx.size();
        send_meas(7'd127, lat);
        chk("stall_lat", lat, 8);
        repeat (5) begin
            @(negedge clk);
            chk("stall_ascii", ascii_out, 8'h31);
            chk("stall_valid", out_valid, 1'b1);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        exp_q.delete();
        fmt(127);
        wait_bytes(4);
        cmp_exp("stall_byte");

        // Overflow: six back-to-back pulses, sink blocked
        out_ready = 1'b0;
        base = rx.size();
        @(posedge clk); #1;
        valid = 1'b1; result = 7'd10;
        for (int k = 2; k <= 6; k++) begin
            @(posedge clk); #1;
            result = 7'(k * 10);
        end
        @(posedge clk); #1;
        valid = 1'b0;
        chk("ovf_flag",  overflow,   1'b1);
        chk("ovf_count", fifo_count, 4);
        chk("ovf_busy",  busy,       1'b1);
        out_ready = 1'b1;
        exp_q.delete();
        for (int k = 1; k <= 5; k++) begin
            exp_q.push_back(8'(8'h30 + k));
            exp_q.push_back(8'h30);
            exp_q.push_back(8'h0A);
        end
        wait_bytes(15);
        cmp_exp("ovf_byte");
        repeat (5) @(posedge clk);
        #1 chk("ovf_sticky", overflow, 1'b1);

        // Async reset mid-emission of 123, after the first digit was taken
        base = rx.size();
        send_meas(7'd123, lat);
        wait_bytes(1);
        if (rx.size() > base) chk("mid_first", rx[base], 8'h31);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", out_valid,  1'b0);
        chk("arst_ascii", ascii_out,  8'h00);
        chk("arst_count", fifo_count, 0);
        chk("arst_ovf",   overflow,   1'b0);
        @(posedge clk); #1 rst = 1'b0;
        base = rx.size();
        repeat (30) @(posedge clk);
        #1 chk("arst_nobytes", rx.size() - base, 0);
        chk("arst_busy", busy, 1'b0);

        // Random spacing and random sink readiness
        base = rx.size();
        exp_q.delete();
        gap = 0;
        sent = 0;
        while (sent < 200) begin
            @(posedge clk); #1;
            out_ready = 1'($urandom_range(0, 1));
            valid = 1'b0;
            if (gap == 0) begin
                valid  = 1'b1;
                result = 7'($urandom_range(0, 127));
                fmt(int'(result));
                sent++;
                gap = $urandom_range(14, 30);
            end else begin
                gap--;
            end
        end
        @(posedge clk); #1;
        valid = 1'b0;
        out_ready = 1'b1;
        wait_bytes(exp_q.size());
        cmp_exp("rand_byte");
        chk("rand_ovf", overflow, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
